// File: rtl/lcd_spi_pkg.sv
// Shared LCD serial-link definitions: command opcodes, panel defaults, decoder states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package lcd_spi_pkg;

   // Panel geometry defaults, shared with the transmitter side
   localparam int LCD_W_DFLT = 132;
   localparam int LCD_H_DFLT = 162;

   // Command opcodes recognised by the decoder
   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   // Byte-level decoder states
   typedef enum logic [2:0] {
      CMD_WAIT  = 3'd0,
      CASET_ARG = 3'd1,
      RASET_ARG = 3'd2,
      RAMWR_HI  = 3'd3,
      RAMWR_LO  = 3'd4
   } dec_state_t;

endpackage

// File: rtl/lcd_spi_rx_deser.sv
// Serial front end: synchronizes the SPI pins, detects lcd_clk rising edges, assembles bytes.
// Latency: pin edge of the 8th bit to o_byte_vld is SYNC_STAGES+2 clk cycles.
// Backpressure: none; o_byte_vld is a one-cycle pulse the consumer must take. SYNC_STAGES >= 2.
module lcd_spi_rx_deser #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_lcd_rst_n,
   input  logic       i_cs_n,
   input  logic       i_sclk,
   input  logic       i_sdat,
   input  logic       i_dc,
   output logic       o_dec_rst,
`ifdef LCD_SPI_RX_CHECK_EN
   output logic       o_cs_abort,
`endif
   output logic       o_byte_vld,
   output logic [7:0] o_byte_dat,
   output logic       o_byte_dc
);

   localparam int L = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] r_cs_sync, r_clk_sync, r_dat_sync, r_dc_sync, r_rstn_sync;
   logic                   r_clk_prev, r_cs_prev;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shift;
   logic                   r_full, r_full_dc;
   logic                   w_clk_rise, w_cs_rise;

   // Synchronizers are left out of reset so they track the pins throughout reset
   // and no false edge is seen when reset releases.
   always_ff @(posedge clk) begin
      r_cs_sync   <= {r_cs_sync[L-1:0],   i_cs_n};
      r_clk_sync  <= {r_clk_sync[L-1:0],  i_sclk};
      r_dat_sync  <= {r_dat_sync[L-1:0],  i_sdat};
      r_dc_sync   <= {r_dc_sync[L-1:0],   i_dc};
      r_rstn_sync <= {r_rstn_sync[L-1:0], i_lcd_rst_n};
      r_clk_prev  <= r_clk_sync[L];
      r_cs_prev   <= r_cs_sync[L];
   end

   assign o_dec_rst  = rst | ~r_rstn_sync[L];
   assign w_clk_rise = r_clk_sync[L] & ~r_clk_prev;
   assign w_cs_rise  = r_cs_sync[L] & ~r_cs_prev;
`ifdef LCD_SPI_RX_CHECK_EN
   assign o_cs_abort = w_cs_rise && (r_bit_cnt != 3'd0) && !o_dec_rst;
`endif

   // Bit counter and shift register; deselect drops any partial byte
   always_ff @(posedge clk) begin
      if (o_dec_rst) begin
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
         r_full    <= 1'b0;
         r_full_dc <= 1'b0;
      end else begin
         r_full <= 1'b0;
         if (w_cs_rise) begin
            r_bit_cnt <= 3'd0;
         end else if (w_clk_rise && !r_cs_sync[L]) begin
            r_shift   <= {r_shift[6:0], r_dat_sync[L]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_full    <= 1'b1;
               r_full_dc <= r_dc_sync[L];
            end
         end
      end
   end

   // Registered byte output pulse
   always_ff @(posedge clk) begin
      if (o_dec_rst) begin
         o_byte_vld <= 1'b0;
         o_byte_dat <= 8'h00;
         o_byte_dc  <= 1'b0;
      end else begin
         o_byte_vld <= r_full;
         if (r_full) begin
            o_byte_dat <= r_shift;
            o_byte_dc  <= r_full_dc;
         end
      end
   end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI receive monitor: decodes bytes into CASET/RASET windows and RAMWR pixel writes.
// Latency: pix_valid one clk after the low byte's byte_valid. Optional checks: LCD_SPI_RX_CHECK_EN.
// Backpressure: none; all outputs are one-cycle pulses or held state.
module lcd_spi_rx
   import lcd_spi_pkg::*;
#(
   parameter int LCD_W       = LCD_W_DFLT,
   parameter int LCD_H       = LCD_H_DFLT,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lcd_rst_n_in,
   input  logic        lcd_cs_n_in,
   input  logic        lcd_clk_in,
   input  logic        lcd_data_in,
   input  logic        lcd_dc_in,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_dc,
   output logic [7:0]  cmd_cur,
   output logic        pix_valid,
   output logic [7:0]  pix_x,
   output logic [7:0]  pix_y,
   output logic [15:0] pix_data,
`ifdef LCD_SPI_RX_CHECK_EN
   output logic [2:0]  err_sticky,
   output logic [15:0] pix_count,
`endif
   output logic        frame_done
);

   localparam logic [7:0] XMAX = 8'(LCD_W - 1);
   localparam logic [7:0] YMAX = 8'(LCD_H - 1);

   logic       w_dec_rst;
`ifdef LCD_SPI_RX_CHECK_EN
   logic       w_cs_abort;
`endif
   dec_state_t r_state;
   logic [7:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y;
   logic [1:0] r_arg_cnt;
   logic [7:0] r_arg_lo, r_pix_hi;
   logic       w_x_wrap, w_y_wrap;

   lcd_spi_rx_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
      .clk         (clk),
      .rst         (rst),
      .i_lcd_rst_n (lcd_rst_n_in),
      .i_cs_n      (lcd_cs_n_in),
      .i_sclk      (lcd_clk_in),
      .i_sdat      (lcd_data_in),
      .i_dc        (lcd_dc_in),
      .o_dec_rst   (w_dec_rst),
`ifdef LCD_SPI_RX_CHECK_EN
      .o_cs_abort  (w_cs_abort),
`endif
      .o_byte_vld  (byte_valid),
      .o_byte_dat  (byte_data),
      .o_byte_dc   (byte_dc)
   );

   // A start beyond the end never matches xe/ye, so the panel edge wraps it instead
   assign w_x_wrap = (r_x == r_xe) || (r_x == XMAX);
   assign w_y_wrap = (r_y == r_ye) || (r_y == YMAX);

   // Command decoder, window registers, cursor and pixel output
   always_ff @(posedge clk) begin
      if (w_dec_rst) begin
         r_state    <= CMD_WAIT;
         cmd_cur    <= 8'h00;
         r_xs       <= 8'h00;
         r_xe       <= XMAX;
         r_ys       <= 8'h00;
         r_ye       <= YMAX;
         r_x        <= 8'h00;
         r_y        <= 8'h00;
         r_arg_cnt  <= 2'd0;
         r_arg_lo   <= 8'h00;
         r_pix_hi   <= 8'h00;
         pix_valid  <= 1'b0;
         pix_x      <= 8'h00;
         pix_y      <= 8'h00;
         pix_data   <= 16'h0000;
         frame_done <= 1'b0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (byte_valid && !byte_dc) begin
            // Commands abort any argument list or half pixel in progress
            cmd_cur   <= byte_data;
            r_arg_cnt <= 2'd0;
            case (byte_data)
               CMD_CASET: r_state <= CASET_ARG;
               CMD_RASET: r_state <= RASET_ARG;
               CMD_RAMWR: begin
                  r_state <= RAMWR_HI;
                  r_x     <= r_xs;
                  r_y     <= r_ys;
               end
               default:   r_state <= CMD_WAIT;
            endcase
         end else if (byte_valid) begin
            case (r_state)
               CASET_ARG, RASET_ARG: begin
                  r_arg_cnt <= r_arg_cnt + 2'd1;
                  if (r_arg_cnt == 2'd1) r_arg_lo <= byte_data;
                  if (r_arg_cnt == 2'd3) begin
                     if (r_state == CASET_ARG) begin
                        r_xs <= r_arg_lo;
                        r_xe <= byte_data;
                     end else begin
                        r_ys <= r_arg_lo;
                        r_ye <= byte_data;
                     end
                     r_state <= CMD_WAIT;
                  end
               end
               RAMWR_HI: begin
                  r_pix_hi <= byte_data;
                  r_state  <= RAMWR_LO;
               end
               RAMWR_LO: begin
                  pix_valid <= 1'b1;
                  pix_x     <= r_x;
                  pix_y     <= r_y;
                  pix_data  <= {r_pix_hi, byte_data};
                  r_state   <= RAMWR_HI;
                  if (w_x_wrap) begin
                     r_x <= r_xs;
                     if (w_y_wrap) begin
                        r_y        <= r_ys;
                        frame_done <= 1'b1;
                     end else begin
                        r_y <= r_y + 8'd1;
                     end
                  end else begin
                     r_x <= r_x + 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef LCD_SPI_RX_CHECK_EN
   // Sticky protocol errors and per-RAMWR pixel count
   always_ff @(posedge clk) begin
      if (w_dec_rst) begin
         err_sticky <= 3'b000;
         pix_count  <= 16'h0000;
      end else begin
         if (w_cs_abort) err_sticky[0] <= 1'b1;
         if (byte_valid && byte_dc && r_state == RAMWR_LO && (r_x > XMAX || r_y > YMAX))
            err_sticky[1] <= 1'b1;
         if (byte_valid && !byte_dc && r_state == RAMWR_LO) err_sticky[2] <= 1'b1;
         if (byte_valid && !byte_dc && byte_data == CMD_RAMWR)
            pix_count <= 16'h0000;
         else if (byte_valid && byte_dc && r_state == RAMWR_LO)
            pix_count <= pix_count + 16'd1;
      end
   end
`endif

endmodule
